// File: rtl/lcd_8080_ctrl.sv
// Avalon-MM slave that posts command/data words through a FIFO onto an
// Intel-8080-style LCD bus, and runs single LCD data reads on request.
module lcd_8080_ctrl #(
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned T_WR_LOW   = 2,
  parameter int unsigned T_WR_HIGH  = 2,
  parameter int unsigned T_RD_LOW   = 8,
  parameter int unsigned T_RD_HIGH  = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [2:0]  avs_address,
  input  logic        avs_write,
  input  logic [31:0] avs_writedata,
  input  logic        avs_read,
  output logic [31:0] avs_readdata,
  output logic        avs_waitrequest,
  output logic        lcd_cs_n,
  output logic        lcd_reset_n,
  output logic [15:0] lcd_data_o,
  input  logic [15:0] lcd_data_i,
  output logic        lcd_data_oe,
  output logic        lcd_rd_n,
  output logic        lcd_wr_n,
  output logic        lcd_dc,
  output logic        lcd_im0
);

  localparam int unsigned AW      = $clog2(FIFO_DEPTH);
  localparam int unsigned LW      = AW + 1;
  localparam int unsigned CW      = 16;
  localparam int unsigned ENTRY_W = 17;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_SETUP   = 3'd1;
  localparam logic [2:0] S_WR_LOW  = 3'd2;
  localparam logic [2:0] S_WR_HIGH = 3'd3;
  localparam logic [2:0] S_RD_LOW  = 3'd4;
  localparam logic [2:0] S_RD_HIGH = 3'd5;
  localparam logic [2:0] S_RD_DONE = 3'd6;

  logic [ENTRY_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic [LW-1:0]      level;
  logic [ENTRY_W-1:0] head;
  logic               fifo_empty;
  logic               fifo_full;
  logic               push_req;
  logic               push;
  logic               pop;
  logic               rd_req;
  logic               rd_active;
  logic               busy;

  logic [2:0]         state, state_d;
  logic [CW-1:0]      cnt, cnt_d;
  logic               is_rd, is_rd_d;
  logic [ENTRY_W-1:0] cur, cur_d;
  logic [15:0]        capt, capt_d;
  logic [1:0]         ctrl;

  logic               cs_d, wr_d, rd_d, oe_d, dc_d;
  logic [15:0]        data_d;
  logic               unused_bits;

  assign unused_bits = ^avs_writedata[31:16];

  assign fifo_empty = (level == '0);
  assign fifo_full  = (level == LW'(FIFO_DEPTH));
  assign head       = mem[rd_ptr];
  assign rd_req     = avs_read && (avs_address == 3'd4);
  assign push_req   = avs_write && (avs_address[2:1] == 2'b00);
  // Posted writes are held off while an LCD read owns the bus.
  assign rd_active  = ((state == S_SETUP) && is_rd) || (state == S_RD_LOW) ||
                      (state == S_RD_HIGH);
  assign push       = push_req && !fifo_full && !rd_active;
  assign busy       = (state != S_IDLE) || !fifo_empty;

  assign lcd_reset_n = ctrl[0];
  assign lcd_im0     = ctrl[1];

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {avs_address[0], avs_writedata[15:0]};
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ctrl <= 2'b00;
    end else if (avs_write && (avs_address == 3'd2)) begin
      ctrl <= avs_writedata[1:0];
    end
  end

  always_comb begin
    avs_waitrequest = 1'b0;
    if (reset_n) begin
      if (push_req && (fifo_full || rd_active)) avs_waitrequest = 1'b1;
      if (rd_req && (state != S_RD_DONE))      avs_waitrequest = 1'b1;
    end
  end

  always_comb begin
    avs_readdata = '0;
    if (avs_read) begin
      case (avs_address)
        3'd2:    avs_readdata = {30'd0, ctrl};
        3'd3:    avs_readdata = {16'd0, 8'(level), 6'd0, fifo_full, busy};
        3'd4:    if (state == S_RD_DONE) avs_readdata = {16'd0, capt};
        default: avs_readdata = '0;
      endcase
    end
  end

  // Bus outputs are registered from the current state, so each strobe
  // phase lags the state that requests it by one clock.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    is_rd_d = is_rd;
    cur_d   = cur;
    capt_d  = capt;
    pop     = 1'b0;
    cs_d    = 1'b1;
    wr_d    = 1'b1;
    rd_d    = 1'b1;
    oe_d    = 1'b0;
    dc_d    = lcd_dc;
    data_d  = lcd_data_o;
    case (state)
      S_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          cur_d   = head;
          is_rd_d = 1'b0;
          state_d = S_SETUP;
        end else if (rd_req) begin
          is_rd_d = 1'b1;
          state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        cs_d = 1'b0;
        if (is_rd) begin
          dc_d    = 1'b1;
          cnt_d   = CW'(T_RD_LOW - 1);
          state_d = S_RD_LOW;
        end else begin
          dc_d    = cur[16];
          data_d  = cur[15:0];
          oe_d    = 1'b1;
          cnt_d   = CW'(T_WR_LOW - 1);
          state_d = S_WR_LOW;
        end
      end
      S_WR_LOW: begin
        cs_d = 1'b0;
        wr_d = 1'b0;
        oe_d = 1'b1;
        if (cnt == '0) begin
          cnt_d   = CW'(T_WR_HIGH - 1);
          state_d = S_WR_HIGH;
        end else begin
          cnt_d = cnt - CW'(1);
        end
      end
      S_WR_HIGH: begin
        cs_d = 1'b0;
        oe_d = 1'b1;
        if (cnt != '0) begin
          cnt_d = cnt - CW'(1);
        end else if (!fifo_empty) begin
          pop     = 1'b1;
          cur_d   = head;
          state_d = S_SETUP;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RD_LOW: begin
        cs_d = 1'b0;
        rd_d = 1'b0;
        if (cnt == '0) begin
          cnt_d   = CW'(T_RD_HIGH - 1);
          state_d = S_RD_HIGH;
        end else begin
          cnt_d = cnt - CW'(1);
        end
      end
      S_RD_HIGH: begin
        cs_d = 1'b0;
        // The registered rd_n is still low on this edge: last sample point.
        if (cnt == CW'(T_RD_HIGH - 1)) capt_d = lcd_data_i;
        if (cnt == '0) begin
          state_d = S_RD_DONE;
        end else begin
          cnt_d = cnt - CW'(1);
        end
      end
      S_RD_DONE: begin
        is_rd_d = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      cnt         <= '0;
      is_rd       <= 1'b0;
      cur         <= '0;
      capt        <= '0;
      lcd_cs_n    <= 1'b1;
      lcd_wr_n    <= 1'b1;
      lcd_rd_n    <= 1'b1;
      lcd_data_oe <= 1'b0;
      lcd_dc      <= 1'b0;
      lcd_data_o  <= '0;
    end else begin
      state       <= state_d;
      cnt         <= cnt_d;
      is_rd       <= is_rd_d;
      cur         <= cur_d;
      capt        <= capt_d;
      lcd_cs_n    <= cs_d;
      lcd_wr_n    <= wr_d;
      lcd_rd_n    <= rd_d;
      lcd_data_oe <= oe_d;
      lcd_dc      <= dc_d;
      lcd_data_o  <= data_d;
    end
  end

endmodule

// File: tb/tb_lcd_8080_ctrl.sv
// Scoreboard bench for lcd_8080_ctrl: posted words and read data are queued
// as expectations when driven and compared when they appear on the bus.
module tb_lcd_8080_ctrl;

  localparam int T_WR_LOW  = 2;
  localparam int T_WR_HIGH = 2;
  localparam int T_RD_LOW  = 8;
  localparam int T_RD_HIGH = 4;
  localparam int BUDGET    = 2000;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  avs_address;
  logic        avs_write;
  logic [31:0] avs_writedata;
  logic        avs_read;
  logic [31:0] avs_readdata;
  logic        avs_waitrequest;
  logic        lcd_cs_n;
  logic        lcd_reset_n;
  logic [15:0] lcd_data_o;
  logic [15:0] lcd_data_i;
  logic        lcd_data_oe;
  logic        lcd_rd_n;
  logic        lcd_wr_n;
  logic        lcd_dc;
  logic        lcd_im0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [16:0] exp_q[$];
  logic [31:0] rd_exp[$];
  int          wr_fall_hist[$];
  int          cs_fall_cyc = -1;
  int          cs_rise_cnt = 0;
  int          rd_fall_cnt = 0;
  int          wr_len = 0;
  int          rd_len = 0;
  logic        prev_cs = 1'b1;
  logic        prev_wr = 1'b1;
  logic        prev_rd = 1'b1;

  lcd_8080_ctrl #(
    .FIFO_DEPTH(16), .T_WR_LOW(T_WR_LOW), .T_WR_HIGH(T_WR_HIGH),
    .T_RD_LOW(T_RD_LOW), .T_RD_HIGH(T_RD_HIGH)
  ) dut (
    .clk(clk), .reset_n(reset_n), .avs_address(avs_address),
    .avs_write(avs_write), .avs_writedata(avs_writedata), .avs_read(avs_read),
    .avs_readdata(avs_readdata), .avs_waitrequest(avs_waitrequest),
    .lcd_cs_n(lcd_cs_n), .lcd_reset_n(lcd_reset_n), .lcd_data_o(lcd_data_o),
    .lcd_data_i(lcd_data_i), .lcd_data_oe(lcd_data_oe), .lcd_rd_n(lcd_rd_n),
    .lcd_wr_n(lcd_wr_n), .lcd_dc(lcd_dc), .lcd_im0(lcd_im0)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Bus monitor: strobe widths, ordering and output-enable rules.
  always @(negedge clk) begin
    if (cyc >= 1) begin
      if (prev_cs && !lcd_cs_n) cs_fall_cyc = cyc;
      if (!prev_cs && lcd_cs_n) cs_rise_cnt++;
      if (!lcd_wr_n) begin
        if (prev_wr) wr_fall_hist.push_back(cyc);
        wr_len++;
        check_eq("wr_oe", 32'(lcd_data_oe), 32'd1);
        check_eq("wr_cs", 32'(lcd_cs_n), 32'd0);
      end else if (!prev_wr) begin
        if (reset_n) begin
          check_eq("wr_width", 32'(wr_len), 32'(T_WR_LOW));
          if (exp_q.size() == 0) check_eq("wr_unexpected", 32'd1, 32'd0);
          else check_eq("wr_word", 32'({lcd_dc, lcd_data_o}), 32'(exp_q.pop_front()));
        end
        wr_len = 0;
      end
      if (!lcd_rd_n) begin
        if (prev_rd) begin
          rd_fall_cnt++;
          check_eq("rd_after_wr", 32'(exp_q.size()), 32'd0);
        end
        rd_len++;
        check_eq("rd_oe", 32'(lcd_data_oe), 32'd0);
        check_eq("rd_dc", 32'(lcd_dc), 32'd1);
      end else if (!prev_rd) begin
        if (reset_n) check_eq("rd_width", 32'(rd_len), 32'(T_RD_LOW));
        rd_len = 0;
      end
      prev_cs = lcd_cs_n;
      prev_wr = lcd_wr_n;
      prev_rd = lcd_rd_n;
    end
  end

  task automatic av_write(input logic [2:0] a, input logic [15:0] d,
                          output int stalls, output int acc);
    int n = 0;
    @(negedge clk);
    avs_address   = a;
    avs_writedata = {16'hDEAD, d};
    avs_write     = 1'b1;
    #1;
    while (avs_waitrequest && n < BUDGET) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (avs_waitrequest) check_eq("wr_timeout", 32'd1, 32'd0);
    @(posedge clk);
    #1;
    avs_write = 1'b0;
    acc = cyc;
    stalls = n;
    if (a < 3'd2) exp_q.push_back({a[0], d});
  endtask

  task automatic av_read(input logic [2:0] a, output logic [31:0] d, output int waits);
    int n = 0;
    @(negedge clk);
    avs_address = a;
    avs_read    = 1'b1;
    #1;
    while (avs_waitrequest && n < BUDGET) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (avs_waitrequest) check_eq("rd_timeout", 32'd1, 32'd0);
    d = avs_readdata;
    waits = n;
    @(posedge clk);
    #1;
    if (a == 3'd4) check_eq("rd_single", 32'(avs_waitrequest), 32'd1);
    avs_read = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((exp_q.size() != 0 || !lcd_cs_n) && n < BUDGET) begin
      @(negedge clk);
      n++;
    end
    if (n >= BUDGET) check_eq("drain_timeout", 32'd0, 32'd1);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    int st, acc, w, base, rise_base, fall_base, tot, mx, first16;
    reset_n = 1'b0;
    avs_address = '0; avs_write = 1'b0; avs_writedata = '0; avs_read = 1'b0;
    lcd_data_i = 16'hABCD;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;

    // Reset state
    @(negedge clk);
    check_eq("rst_cs", 32'(lcd_cs_n), 32'd1);
    check_eq("rst_wr", 32'(lcd_wr_n), 32'd1);
    check_eq("rst_rd", 32'(lcd_rd_n), 32'd1);
    check_eq("rst_oe", 32'(lcd_data_oe), 32'd0);
    check_eq("rst_lcdrst", 32'(lcd_reset_n), 32'd0);
    check_eq("rst_im0", 32'(lcd_im0), 32'd0);
    check_eq("rst_wait", 32'(avs_waitrequest), 32'd0);
    av_read(3'd3, rd, w);
    check_eq("rst_status", rd, 32'h0);

    // CTRL register, ignored and unused addresses
    av_write(3'd2, 16'h0003, st, acc);
    check_eq("ctrl_nostall", 32'(st), 32'd0);
    @(negedge clk);
    check_eq("ctrl_lcdrst", 32'(lcd_reset_n), 32'd1);
    check_eq("ctrl_im0", 32'(lcd_im0), 32'd1);
    av_read(3'd2, rd, w);
    check_eq("ctrl_read", rd, 32'h3);
    av_write(3'd5, 16'hFFFF, st, acc);
    check_eq("addr5_nostall", 32'(st), 32'd0);
    av_read(3'd3, rd, w);
    check_eq("addr5_ignored", rd, 32'h0);
    av_read(3'd6, rd, w);
    check_eq("addr6_zero", rd, 32'h0);

    // Command then data, back-to-back
    fall_base = wr_fall_hist.size();
    rise_base = cs_rise_cnt;
    av_write(3'd0, 16'h002C, st, base);
    av_write(3'd1, 16'hF800, st, acc);
    wait_drain();
    check_eq("cs_fall_time", 32'(cs_fall_cyc), 32'(base + 2));
    check_eq("wr_pulses", 32'(wr_fall_hist.size() - fall_base), 32'd2);
    if (wr_fall_hist.size() >= fall_base + 2) begin
      check_eq("wr_fall_time", 32'(wr_fall_hist[fall_base]), 32'(base + 3));
      check_eq("wr_period", 32'(wr_fall_hist[fall_base+1] - wr_fall_hist[fall_base]),
               32'(1 + T_WR_LOW + T_WR_HIGH));
    end
    check_eq("cs_held", 32'(cs_rise_cnt - rise_base), 32'd1);

    // Burst beyond FIFO depth
    tot = 0; mx = 0; first16 = 0;
    for (int i = 0; i < 24; i++) begin
      av_write(3'd1, 16'(16'h0100 + i * 16'h0111), st, acc);
      tot += st;
      if (st > mx) mx = st;
      if (i < 16) first16 += st;
    end
    check_eq("burst_nostall16", 32'(first16), 32'd0);
    check_eq("burst_stalled", 32'(tot > 0), 32'd1);
    check_eq("burst_stallmax", 32'(mx <= 1 + T_WR_LOW + T_WR_HIGH), 32'd1);
    av_read(3'd3, rd, w);
    check_eq("burst_status_full", rd, 32'h0000_1003);
    wait_drain();
    av_read(3'd3, rd, w);
    check_eq("burst_status_idle", rd, 32'h0);

    // Write then LCD read
    base = rd_fall_cnt;
    av_write(3'd1, 16'h1234, st, acc);
    rd_exp.push_back({16'h0000, lcd_data_i});
    av_read(3'd4, rd, w);
    check_eq("rddata", rd, rd_exp.pop_front());
    check_eq("rd_waits", 32'(w), 32'(2 + 1 + T_WR_LOW + T_WR_HIGH + 1 + T_RD_LOW + T_RD_HIGH));
    check_eq("rd_pulses", 32'(rd_fall_cnt - base), 32'd1);
    wait_drain();

    // Reset in the middle of a write strobe with entries queued
    for (int i = 0; i < 7; i++) av_write(3'd1, 16'(16'h5A00 + i), st, acc);
    w = 0;
    while (lcd_wr_n && w < 100) begin
      @(negedge clk);
      w++;
    end
    check_eq("abort_wr_low", 32'(lcd_wr_n), 32'd0);
    #1 reset_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    #1;
    check_eq("abort_wr", 32'(lcd_wr_n), 32'd1);
    check_eq("abort_cs", 32'(lcd_cs_n), 32'd1);
    check_eq("abort_oe", 32'(lcd_data_oe), 32'd0);
    check_eq("abort_data", 32'(lcd_data_o), 32'd0);
    check_eq("abort_lcdrst", 32'(lcd_reset_n), 32'd0);
    reset_n = 1'b1;
    exp_q.delete();
    fall_base = wr_fall_hist.size();
    av_read(3'd3, rd, w);
    check_eq("abort_status", rd, 32'h0);
    repeat (30) @(negedge clk);
    check_eq("abort_nostrobe", 32'(wr_fall_hist.size() - fall_base), 32'd0);
    check_eq("abort_cs_idle", 32'(lcd_cs_n), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
